// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the flow-controlled UART transmitter.
//   uart_state_t : transmitter FSM state encoding
//   frame_cycles : clock cycles occupied by one complete serial frame
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // One start bit, the data bits, optional parity, then the stop bits,
    // each held for clks_per_bit cycles.
    function automatic int frame_cycles(input int data_w,
                                        input int parity_en,
                                        input int stop_bits,
                                        input int clks_per_bit);
        return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Small synchronous FIFO that buffers bytes waiting for transmission.
// The head entry is readable combinationally so the transmitter can load
// it into its shift register on the same edge that pops it.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers/level)
//   push        : write request, ignored while full
//   push_data   : data written on push
//   pop         : read request, ignored while empty
//   pop_data    : current head entry
//   full, empty : occupancy flags
//   level       : number of stored entries (0..FIFO_DEPTH)
module uart_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_push;
    logic              w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;

endmodule

// File: rtl/uart_tx_fc.sv
// uart_tx_fc
// UART transmitter with a transmit FIFO and CTS flow control. A frame is
// started only while the synchronized CTS is high; once started, a frame
// always runs to completion. Consecutive frames follow with no idle gap.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : write request
//   in_data    : data word to transmit (LSB first)
//   in_ready   : FIFO has room (level != FIFO_DEPTH)
//   cts        : clear-to-send, asynchronous, active high
//   tx         : registered serial output, idle high
//   busy       : a frame is in progress
//   level      : FIFO occupancy
module uart_tx_fc
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          cts,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] w_baud_next;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_parity;
    logic              w_parity_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_cts_meta;
    logic              r_cts_s;

    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_start_ok;
    logic              w_baud_last;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (level)
    );

    // Two-flop synchronizer; only r_cts_s is visible to the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cts_meta <= 1'b0;
            r_cts_s    <= 1'b0;
        end else begin
            r_cts_meta <= cts;
            r_cts_s    <= r_cts_meta;
        end
    end

    assign w_start_ok  = !w_fifo_empty && r_cts_s;
    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    // State register: state, counters, shift register and the tx flop
    // all advance on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
        end
    end

    // Next-state logic. The FIFO head is popped into the shift register on
    // the edge that enters START, both from IDLE and straight out of STOP.
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_pop         = 1'b0;

        if (r_state != ST_IDLE) begin
            w_baud_next = w_baud_last ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_START;
                    w_pop        = 1'b1;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_next = ST_DATA;
                    w_bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next   = r_bit_cnt + 1'b1;
                        w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (w_baud_last) begin
                    w_state_next = ST_STOP;
                    w_bit_next   = '0;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_next = '0;
                        if (w_start_ok) begin
                            w_state_next = ST_START;
                            w_pop        = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_pop) begin
            w_shift_next  = w_fifo_data;
            w_parity_next = (^w_fifo_data) ^ (PARITY_ODD != 0);
        end
    end

    // Output logic: tx is computed from the upcoming state so the tx flop
    // changes in step with the state register.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_IDLE:   w_tx_next = 1'b1;
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = r_parity;
            ST_STOP:   w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE);
    assign in_ready = !w_fifo_full;

endmodule
